// File: rtl/cfg_types_pkg.sv
// Shared types and constants for the keccak absorb-side feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: feeder FSM state encoding, default rate, domain-separation bytes.
package cfg_types_pkg;

  typedef logic [1:0] feeder_state_t;

  localparam feeder_state_t FD_IDLE = 2'd0;
  localparam feeder_state_t FD_MSG  = 2'd1;
  localparam feeder_state_t FD_PAD  = 2'd2;
  localparam feeder_state_t FD_DONE = 2'd3;

  // SHAKE128 rate: 21 lanes of 64 bits = 1344 bits
  localparam int RATE_LANES_C = 21;

  localparam logic [7:0] DS_SHAKE = 8'h1F;
  localparam logic [7:0] DS_SHA3  = 8'h06;

endpackage

// File: rtl/keccak_lane_pad.sv
// Forms one 64-bit little-endian lane: keeps the first r message bytes, inserts the pad-start byte, sets the final pad bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
// Ports: in_data (raw input lane), r (valid message bytes, 8 = full lane), pad_done (pad-start
// byte already emitted), last_lane (last lane of the final block), lane (padded result).
module keccak_lane_pad
  import cfg_types_pkg::*;
#(
  parameter logic [7:0] DS_BYTE = DS_SHAKE
) (
  input  logic [63:0] in_data,
  input  logic [3:0]  r,
  input  logic        pad_done,
  input  logic        last_lane,
  output logic [63:0] lane
);

  always_comb begin
    lane = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < r) begin
        lane[8*i +: 8] = in_data[8*i +: 8];
      end else if ((4'(i) == r) && !pad_done) begin
        lane[8*i +: 8] = DS_BYTE;
      end
    end
    // Closing bit of pad10*1; may share byte 7 with the pad-start byte (1F -> 9F)
    if (last_lane) begin
      lane[63:56] = lane[63:56] | 8'h80;
    end
  end

endmodule

// File: rtl/keccak_pad_feeder.sv
// Absorb feeder: turns a byte-length message lane stream into pad10*1-padded, rate-sized lane blocks for keccak.
// Latency: a lane appears on din one cycle after its input is accepted; done pulses one cycle after the final transfer.
// Backpressure: buffer_full stalls the 1-deep output register; in_ready drops while it cannot be refilled.
// Ports: start/msg_len (message setup, sampled in IDLE), in_data/in_valid/in_ready (message lanes),
// din/din_valid/buffer_full/last_block (keccak side), busy/done (status).
module keccak_pad_feeder
  import cfg_types_pkg::*;
#(
  parameter int         RATE_LANES = RATE_LANES_C,
  parameter int         LEN_W      = 16,
  parameter logic [7:0] DS_BYTE    = DS_SHAKE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      din,
  output logic             din_valid,
  input  logic             buffer_full,
  output logic             last_block,
  output logic             busy,
  output logic             done
);

  localparam int                IDX_W     = $clog2(RATE_LANES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RATE_LANES - 1);
  localparam logic [LEN_W:0]    BLK_BYTES = (LEN_W + 1)'(RATE_LANES * 8);
  localparam logic [LEN_W-1:0]  EIGHT     = LEN_W'(8);

  feeder_state_t    state_q, state_d;
  logic [63:0]      din_q, din_d;
  logic             din_valid_q, din_valid_d;
  logic             last_block_q, last_block_d;
  logic [IDX_W-1:0] lane_idx_q, lane_idx_d;
  logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
  logic             pad_done_q, pad_done_d;
  logic             final_q, final_d;
  // Last lane of the final block is sitting in the output register
  logic             tail_q, tail_d;

  logic             slot_free;
  logic             xfer;
  logic             load;
  logic             final_now;
  logic             last_lane;
  logic [3:0]       r_nib;
  logic [63:0]      pad_lane;

  assign slot_free = !din_valid_q || !buffer_full;
  assign xfer      = din_valid_q && !buffer_full;
  // The final-block decision is taken when lane 0 of a block is loaded and held for the block
  assign final_now = (lane_idx_q == '0) ? ({1'b0, bytes_left_q} < BLK_BYTES) : final_q;
  assign last_lane = final_now && (lane_idx_q == LAST_IDX);
  assign r_nib     = (bytes_left_q >= EIGHT) ? 4'd8 : bytes_left_q[3:0];

  keccak_lane_pad #(.DS_BYTE(DS_BYTE)) u_lane_pad (
    .in_data   (in_data),
    .r         (r_nib),
    .pad_done  (pad_done_q),
    .last_lane (last_lane),
    .lane      (pad_lane)
  );

  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    din_valid_d  = din_valid_q;
    last_block_d = last_block_q;
    lane_idx_d   = lane_idx_q;
    bytes_left_d = bytes_left_q;
    pad_done_d   = pad_done_q;
    final_d      = final_q;
    tail_d       = tail_q;
    load         = 1'b0;

    if (xfer) begin
      din_valid_d = 1'b0;
    end

    case (state_q)
      FD_IDLE: begin
        if (start) begin
          bytes_left_d = msg_len;
          lane_idx_d   = '0;
          pad_done_d   = 1'b0;
          final_d      = 1'b0;
          tail_d       = 1'b0;
          last_block_d = 1'b0;
          state_d      = (msg_len == '0) ? FD_PAD : FD_MSG;
        end
      end
      FD_MSG: begin
        if (in_valid && slot_free) begin
          load = 1'b1;
          if (r_nib == 4'd8) begin
            bytes_left_d = bytes_left_q - EIGHT;
          end else begin
            bytes_left_d = '0;
            pad_done_d   = 1'b1;
          end
          if (bytes_left_d == '0) begin
            state_d = FD_PAD;
          end
        end
      end
      FD_PAD: begin
        if (!tail_q && slot_free) begin
          load       = 1'b1;
          pad_done_d = 1'b1;
        end else if (tail_q && xfer) begin
          state_d = FD_DONE;
        end
      end
      default: begin
        state_d = FD_IDLE;
      end
    endcase

    if (load) begin
      din_d        = pad_lane;
      din_valid_d  = 1'b1;
      last_block_d = final_now;
      final_d      = final_now;
      tail_d       = last_lane;
      lane_idx_d   = (lane_idx_q == LAST_IDX) ? '0 : lane_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FD_IDLE;
      din_q        <= '0;
      din_valid_q  <= 1'b0;
      last_block_q <= 1'b0;
      lane_idx_q   <= '0;
      bytes_left_q <= '0;
      pad_done_q   <= 1'b0;
      final_q      <= 1'b0;
      tail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      din_valid_q  <= din_valid_d;
      last_block_q <= last_block_d;
      lane_idx_q   <= lane_idx_d;
      bytes_left_q <= bytes_left_d;
      pad_done_q   <= pad_done_d;
      final_q      <= final_d;
      tail_q       <= tail_d;
    end
  end

  assign in_ready   = (state_q == FD_MSG) && slot_free;
  assign din        = din_q;
  assign din_valid  = din_valid_q;
  assign last_block = last_block_q;
  assign busy       = (state_q != FD_IDLE);
  assign done       = (state_q == FD_DONE);

endmodule

// File: tb/tb_keccak_pad_feeder.sv
module tb_keccak_pad_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] msg_len;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din;
  logic        din_valid;
  logic        buffer_full;
  logic        last_block;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [63:0] in_lanes[$];
  logic [63:0] exp_d[$];
  logic        exp_l[$];
  logic [63:0] got_d[$];
  logic        got_l[$];

  keccak_pad_feeder #(.RATE_LANES(21), .LEN_W(16), .DS_BYTE(8'h1F)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .msg_len     (msg_len),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din         (din),
    .din_valid   (din_valid),
    .buffer_full (buffer_full),
    .last_block  (last_block),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: message bytes, then 0x1F, zero-fill to a multiple of 168 bytes, OR 0x80 into the last byte
  task automatic build_expected(input int len);
    logic [7:0] pb[$];
    logic [63:0] w;
    int nl;
    pb.delete();
    for (int i = 0; i < len; i++) begin
      w = in_lanes[i/8];
      pb.push_back(w[8*(i%8) +: 8]);
    end
    pb.push_back(8'h1F);
    while ((pb.size() % 168) != 0) pb.push_back(8'h00);
    pb[pb.size()-1] = pb[pb.size()-1] | 8'h80;
    exp_d.delete();
    exp_l.delete();
    nl = pb.size() / 8;
    for (int j = 0; j < nl; j++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = pb[8*j + b];
      exp_d.push_back(w);
      exp_l.push_back(j >= nl - 21);
    end
  endtask

  task automatic random_lanes(input int len);
    in_lanes.delete();
    for (int i = 0; i < (len + 7) / 8; i++) in_lanes.push_back({$urandom, $urandom});
  endtask

  // mode 0: no stall; 1: random stalls, input gaps, ignored start pulses; 2: 10-cycle stall mid-block
  task automatic run_msg(input int len, input int mode, input int abort_at, input string name);
    int n_in;
    int ptr;
    bit prev_stall;
    logic [63:0] prev_din;
    logic prev_last;
    bit saw_done;
    bit last_xf_final;
    bit extra_rdy;
    int n;
    n_in = (len + 7) / 8;
    ptr = 0;
    prev_stall = 0;
    prev_din = '0;
    prev_last = 0;
    saw_done = 0;
    last_xf_final = 0;
    extra_rdy = 0;
    build_expected(len);
    got_d.delete();
    got_l.delete();
    @(negedge clk);
    start = 1;
    msg_len = len[15:0];
    in_valid = 0;
    buffer_full = 0;
    @(posedge clk);
    for (int cyc = 0; cyc < 4000 && !saw_done; cyc++) begin
      @(negedge clk);
      start = 0;
      case (mode)
        1: buffer_full = ($urandom_range(0, 9) < 3);
        2: buffer_full = (cyc >= 8 && cyc < 18);
        default: buffer_full = 0;
      endcase
      if (mode == 1 && busy && $urandom_range(0, 15) == 0) begin
        start = 1;
        msg_len = 16'($urandom);
      end
      if (ptr < n_in && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1;
        in_data = in_lanes[ptr];
      end else begin
        in_valid = 0;
        in_data = {$urandom, $urandom};
      end
      #1;
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_after_start got=%b want=1", name, busy);
        end
      end
      if (prev_stall) begin
        checks++;
        if (din_valid !== 1'b1 || din !== prev_din || last_block !== prev_last) begin
          errors++;
          $display("FAIL %s stall_hold got vld=%b din=%h last=%b want vld=1 din=%h last=%b",
                   name, din_valid, din, last_block, prev_din, prev_last);
        end
      end
      if (din_valid && buffer_full) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready_while_stalled got=%b want=0", name, in_ready);
        end
      end
      if (ptr >= n_in && in_ready) extra_rdy = 1;
      if (done) begin
        saw_done = 1;
        checks++;
        if (!last_xf_final) begin
          errors++;
          $display("FAIL %s done_timing got done=1 lanes_out=%0d want final transfer on previous cycle (%0d lanes)",
                   name, got_d.size(), exp_d.size());
        end
      end
      last_xf_final = 0;
      if (din_valid && !buffer_full) begin
        got_d.push_back(din);
        got_l.push_back(last_block);
        if (got_d.size() == exp_d.size()) last_xf_final = 1;
      end
      if (in_valid && in_ready) ptr++;
      prev_stall = din_valid && buffer_full;
      prev_din = din;
      prev_last = last_block;
      if (abort_at >= 0 && got_d.size() == abort_at) begin
        rst_n = 0;
        #1;
        checks++;
        if (din_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || last_block !== 1'b0) begin
          errors++;
          $display("FAIL %s abort_reset got vld=%b busy=%b rdy=%b last=%b want all 0",
                   name, din_valid, busy, in_ready, last_block);
        end
        in_valid = 0;
        buffer_full = 0;
        @(negedge clk);
        checks++;
        if (din_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s abort_no_valid got=%b want=0", name, din_valid);
        end
        rst_n = 1;
        return;
      end
    end
    in_valid = 0;
    buffer_full = 0;
    start = 0;
    checks++;
    if (!saw_done) begin
      errors++;
      $display("FAIL %s timeout got lanes=%0d want=%0d", name, got_d.size(), exp_d.size());
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_end got done=%b busy=%b want 0 0", name, done, busy);
    end
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL %s lane_count got=%0d want=%0d", name, got_d.size(), exp_d.size());
    end
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL %s lane%0d got din=%h last=%b want din=%h last=%b",
                 name, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (ptr != n_in || extra_rdy) begin
      errors++;
      $display("FAIL %s inputs_consumed got=%0d extra_rdy=%b want=%0d extra_rdy=0", name, ptr, extra_rdy, n_in);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    start = 0;
    msg_len = '0;
    in_data = '0;
    in_valid = 0;
    buffer_full = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (din !== 64'h0 || din_valid !== 1'b0 || last_block !== 1'b0 || in_ready !== 1'b0 ||
        done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset got din=%h vld=%b last=%b rdy=%b done=%b busy=%b want all 0",
               din, din_valid, last_block, in_ready, done, busy);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_len0();
    in_lanes.delete();
    run_msg(0, 0, -1, "len0");
    checks++;
    if (got_d.size() != 21 || got_d[0] !== 64'h1F || got_d[20] !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL len0_const got n=%0d want n=21 lane0=1f lane20=8000000000000000", got_d.size());
    end
  endtask

  task automatic test_len5();
    in_lanes.delete();
    in_lanes.push_back(64'h1122_3344_5566_7788);
    run_msg(5, 0, -1, "len5");
    checks++;
    if (got_d.size() != 21 || got_d[0] !== 64'h0000_1F44_5566_7788 || got_d[20][63] !== 1'b1) begin
      errors++;
      $display("FAIL len5_const got n=%0d lane0=%h want n=21 lane0=00001f4455667788 lane20 bit63",
               got_d.size(), (got_d.size() > 0) ? got_d[0] : 64'h0);
    end
  endtask

  task automatic test_len167();
    random_lanes(167);
    run_msg(167, 0, -1, "len167");
    checks++;
    if (got_d.size() != 21 || got_d[20][63:56] !== 8'h9F || got_d[20][55:0] !== in_lanes[20][55:0]) begin
      errors++;
      $display("FAIL len167_const got n=%0d want n=21 lane20 top byte 9f", got_d.size());
    end
  endtask

  task automatic test_len168();
    random_lanes(168);
    run_msg(168, 0, -1, "len168");
    checks++;
    if (got_d.size() != 42 || got_d[21] !== 64'h1F || got_l[20] !== 1'b0 || got_l[21] !== 1'b1 ||
        got_d[41] !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL len168_const got n=%0d want n=42 with pad block", got_d.size());
    end
  endtask

  task automatic test_stall();
    random_lanes(100);
    run_msg(100, 2, -1, "stall10");
  endtask

  task automatic test_random();
    int lens[6];
    lens[0] = 8;
    lens[1] = 160;
    lens[2] = 161;
    lens[3] = 336;
    lens[4] = $urandom_range(1, 400);
    lens[5] = $urandom_range(1, 400);
    for (int k = 0; k < 6; k++) begin
      random_lanes(lens[k]);
      run_msg(lens[k], 1, -1, $sformatf("rand_len%0d", lens[k]));
    end
  endtask

  task automatic test_midreset();
    random_lanes(300);
    run_msg(300, 0, 7, "abort_at7");
    random_lanes(40);
    run_msg(40, 1, -1, "after_abort");
  endtask

  initial begin
    test_reset();
    test_len0();
    test_len5();
    test_len167();
    test_len168();
    test_stall();
    test_random();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
